// File: rtl/l2_arbiter.sv
// Two-master round-robin wishbone arbiter placing the L1 I-cache and the
// L1 D-cache in front of the unified L2, one line transaction at a time.
module l2_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 128,
  parameter int SEL_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_cyc,
  input  logic              i_stb,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_adr,
  input  logic [SEL_W-1:0]  i_sel,
  input  logic [DATA_W-1:0] i_dat_m,
  output logic              i_ack,
  output logic              i_rty,
  input  logic              d_cyc,
  input  logic              d_stb,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_adr,
  input  logic [SEL_W-1:0]  d_sel,
  input  logic [DATA_W-1:0] d_dat_m,
  output logic              d_ack,
  output logic              d_rty,
  output logic [DATA_W-1:0] dat_s,
  output logic              l2_cyc,
  output logic              l2_stb,
  output logic              l2_we,
  output logic [ADDR_W-1:0] l2_adr,
  output logic [SEL_W-1:0]  l2_sel,
  output logic [DATA_W-1:0] l2_dat_m,
  input  logic [DATA_W-1:0] l2_dat_s,
  input  logic              l2_ack,
  input  logic              l2_rty
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   last_grant_q, last_grant_d;  // 0 = I-cache, 1 = D-cache
  logic   req_i, req_d;

  assign req_i = i_cyc & i_stb;
  assign req_d = d_cyc & d_stb;

  // State and round-robin pointer; reset favours I on the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Next-state logic; l2_rty never ends a grant, only ack or abort does.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (req_i && req_d) begin
          state_d = last_grant_q ? GRANT_I : GRANT_D;
        end else if (req_i) begin
          state_d = GRANT_I;
        end else if (req_d) begin
          state_d = GRANT_D;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT_I: begin
        if (l2_ack || !req_i) begin
          state_d      = IDLE;
          last_grant_d = 1'b0;
        end else begin
          state_d = GRANT_I;
        end
      end
      GRANT_D: begin
        if (l2_ack || !req_d) begin
          state_d      = IDLE;
          last_grant_d = 1'b1;
        end else begin
          state_d = GRANT_D;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Forwarding mux; rst blanks it so a reset mid-grant yields no ack.
  always_comb begin
    l2_cyc   = 1'b0;
    l2_stb   = 1'b0;
    l2_we    = 1'b0;
    l2_adr   = '0;
    l2_sel   = '0;
    l2_dat_m = '0;
    i_ack    = 1'b0;
    d_ack    = 1'b0;
    if (!rst) begin
      case (state_q)
        GRANT_I: begin
          l2_cyc   = i_cyc;
          l2_stb   = i_stb;
          l2_we    = i_we;
          l2_adr   = i_adr;
          l2_sel   = i_sel;
          l2_dat_m = i_dat_m;
          i_ack    = l2_ack;
        end
        GRANT_D: begin
          l2_cyc   = d_cyc;
          l2_stb   = d_stb;
          l2_we    = d_we;
          l2_adr   = d_adr;
          l2_sel   = d_sel;
          l2_dat_m = d_dat_m;
          d_ack    = l2_ack;
        end
        default: begin
          l2_cyc = 1'b0;
        end
      endcase
    end else begin
      l2_cyc = 1'b0;
    end
  end

  assign i_rty = req_i & ~i_ack;
  assign d_rty = req_d & ~d_ack;
  assign dat_s = l2_dat_s;

endmodule

// File: tb/tb_l2_arbiter.sv
// Directed testbench for l2_arbiter: arbitration, forwarding, retry,
// abort and reset behaviour, each scenario checked against hand values.
module tb_l2_arbiter;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 128;
  localparam int SEL_W  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_cyc, i_stb, i_we;
  logic [ADDR_W-1:0] i_adr;
  logic [SEL_W-1:0]  i_sel;
  logic [DATA_W-1:0] i_dat_m;
  logic              i_ack, i_rty;
  logic              d_cyc, d_stb, d_we;
  logic [ADDR_W-1:0] d_adr;
  logic [SEL_W-1:0]  d_sel;
  logic [DATA_W-1:0] d_dat_m;
  logic              d_ack, d_rty;
  logic [DATA_W-1:0] dat_s;
  logic              l2_cyc, l2_stb, l2_we;
  logic [ADDR_W-1:0] l2_adr;
  logic [SEL_W-1:0]  l2_sel;
  logic [DATA_W-1:0] l2_dat_m;
  logic [DATA_W-1:0] l2_dat_s;
  logic              l2_ack, l2_rty;

  int checks = 0;
  int errors = 0;

  localparam logic [DATA_W-1:0] D_WDATA = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_CAFE_F00D;

  always #5 clk = ~clk;

  l2_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SEL_W(SEL_W)) dut (
    .clk(clk), .rst(rst),
    .i_cyc(i_cyc), .i_stb(i_stb), .i_we(i_we), .i_adr(i_adr), .i_sel(i_sel),
    .i_dat_m(i_dat_m), .i_ack(i_ack), .i_rty(i_rty),
    .d_cyc(d_cyc), .d_stb(d_stb), .d_we(d_we), .d_adr(d_adr), .d_sel(d_sel),
    .d_dat_m(d_dat_m), .d_ack(d_ack), .d_rty(d_rty),
    .dat_s(dat_s),
    .l2_cyc(l2_cyc), .l2_stb(l2_stb), .l2_we(l2_we), .l2_adr(l2_adr),
    .l2_sel(l2_sel), .l2_dat_m(l2_dat_m),
    .l2_dat_s(l2_dat_s), .l2_ack(l2_ack), .l2_rty(l2_rty)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    i_cyc = 1'b0; i_stb = 1'b0; i_we = 1'b0; i_adr = '0; i_sel = '0; i_dat_m = '0;
    d_cyc = 1'b0; d_stb = 1'b0; d_we = 1'b0; d_adr = '0; d_sel = '0; d_dat_m = '0;
    l2_dat_s = '0; l2_ack = 1'b0; l2_rty = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic req_i_on(input logic [ADDR_W-1:0] adr);
    i_cyc = 1'b1; i_stb = 1'b1; i_we = 1'b0; i_adr = adr; i_sel = 16'hFFFF;
  endtask

  task automatic req_d_on(input logic [ADDR_W-1:0] adr, input logic we);
    d_cyc = 1'b1; d_stb = 1'b1; d_we = we; d_adr = adr; d_sel = 16'hFFFF;
    d_dat_m = D_WDATA;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    req_i_on(12'h055);
    l2_ack = 1'b1;
    l2_dat_s = 128'h1234;
    tick();
    settle();
    checks++; if (l2_cyc !== 1'b0 || l2_stb !== 1'b0) begin errors++; $display("FAIL reset_l2_cyc_stb got %b%b exp 00", l2_cyc, l2_stb); end
    checks++; if (i_ack !== 1'b0 || d_ack !== 1'b0) begin errors++; $display("FAIL reset_acks got %b%b exp 00", i_ack, d_ack); end
    checks++; if (i_rty !== 1'b1 || d_rty !== 1'b0) begin errors++; $display("FAIL reset_rty got %b%b exp 10", i_rty, d_rty); end
    checks++; if (dat_s !== 128'h1234) begin errors++; $display("FAIL dat_s_passthru got %h exp %h", dat_s, 128'h1234); end
    rst = 1'b0;
    settle();
    checks++; if (l2_cyc !== 1'b0 || l2_adr !== 12'h000 || i_ack !== 1'b0) begin errors++; $display("FAIL post_reset_idle got cyc=%b adr=%h ack=%b exp 0/000/0", l2_cyc, l2_adr, i_ack); end
    clear_inputs();
  endtask

  task automatic test_single_read();
    do_reset();
    req_i_on(12'h012);
    settle();
    checks++; if (l2_stb !== 1'b0 || i_rty !== 1'b1) begin errors++; $display("FAIL single_c1 got stb=%b rty=%b exp 0/1", l2_stb, i_rty); end
    tick(); settle();
    checks++; if (l2_cyc !== 1'b1 || l2_adr !== 12'h012 || l2_we !== 1'b0 || i_rty !== 1'b1) begin errors++; $display("FAIL single_c2 got cyc=%b adr=%h we=%b rty=%b exp 1/012/0/1", l2_cyc, l2_adr, l2_we, i_rty); end
    tick(); settle();
    checks++; if (l2_stb !== 1'b1 || i_ack !== 1'b0) begin errors++; $display("FAIL single_c3 got stb=%b ack=%b exp 1/0", l2_stb, i_ack); end
    tick();
    l2_ack = 1'b1;
    settle();
    checks++; if (i_ack !== 1'b1 || i_rty !== 1'b0 || d_ack !== 1'b0) begin errors++; $display("FAIL single_c4 got iack=%b irty=%b dack=%b exp 1/0/0", i_ack, i_rty, d_ack); end
    tick();
    l2_ack = 1'b0;
    i_cyc = 1'b0; i_stb = 1'b0;
    settle();
    checks++; if (l2_stb !== 1'b0 || l2_cyc !== 1'b0) begin errors++; $display("FAIL single_c5 got stb=%b cyc=%b exp 0/0", l2_stb, l2_cyc); end
  endtask

  task automatic test_both_from_reset();
    do_reset();
    req_i_on(12'h100);
    req_d_on(12'h200, 1'b1);
    settle();
    checks++; if (l2_cyc !== 1'b0 || d_rty !== 1'b1 || i_rty !== 1'b1) begin errors++; $display("FAIL both_idle got cyc=%b drty=%b irty=%b exp 0/1/1", l2_cyc, d_rty, i_rty); end
    tick(); settle();
    checks++; if (l2_adr !== 12'h100 || l2_we !== 1'b0 || d_rty !== 1'b1) begin errors++; $display("FAIL both_i_first got adr=%h we=%b drty=%b exp 100/0/1", l2_adr, l2_we, d_rty); end
    tick();
    l2_ack = 1'b1;
    settle();
    checks++; if (i_ack !== 1'b1 || d_ack !== 1'b0 || d_rty !== 1'b1) begin errors++; $display("FAIL both_i_ack got iack=%b dack=%b drty=%b exp 1/0/1", i_ack, d_ack, d_rty); end
    tick();
    l2_ack = 1'b0;
    i_cyc = 1'b0; i_stb = 1'b0;
    settle();
    checks++; if (l2_cyc !== 1'b0 || d_rty !== 1'b1) begin errors++; $display("FAIL both_gap got cyc=%b drty=%b exp 0/1", l2_cyc, d_rty); end
    tick(); settle();
    checks++; if (l2_adr !== 12'h200 || l2_we !== 1'b1 || l2_sel !== 16'hFFFF) begin errors++; $display("FAIL both_d_fwd got adr=%h we=%b sel=%h exp 200/1/ffff", l2_adr, l2_we, l2_sel); end
    checks++; if (l2_dat_m !== D_WDATA) begin errors++; $display("FAIL both_d_data got %h exp %h", l2_dat_m, D_WDATA); end
    l2_ack = 1'b1;
    settle();
    checks++; if (d_ack !== 1'b1 || i_ack !== 1'b0) begin errors++; $display("FAIL both_d_ack got dack=%b iack=%b exp 1/0", d_ack, i_ack); end
    tick();
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    logic exp_d;
    do_reset();
    req_i_on(12'h111);
    req_d_on(12'h222, 1'b0);
    exp_d = 1'b0;
    for (int t = 0; t < 4; t++) begin
      settle();
      checks++; if (l2_cyc !== 1'b0) begin errors++; $display("FAIL b2b_idle_%0d got cyc=%b exp 0", t, l2_cyc); end
      tick();
      l2_ack = 1'b1;
      settle();
      checks++; if (l2_adr !== (exp_d ? 12'h222 : 12'h111)) begin errors++; $display("FAIL b2b_order_%0d got adr=%h exp %h", t, l2_adr, exp_d ? 12'h222 : 12'h111); end
      checks++; if (i_ack !== ~exp_d || d_ack !== exp_d) begin errors++; $display("FAIL b2b_ack_%0d got iack=%b dack=%b exp %b/%b", t, i_ack, d_ack, ~exp_d, exp_d); end
      tick();
      l2_ack = 1'b0;
      exp_d = ~exp_d;
    end
    clear_inputs();
  endtask

  task automatic test_retry_hold();
    do_reset();
    req_d_on(12'h3A5, 1'b0);
    tick();
    req_i_on(12'h044);
    l2_rty = 1'b1;
    for (int c = 0; c < 10; c++) begin
      settle();
      checks++; if (l2_cyc !== 1'b1 || l2_adr !== 12'h3A5 || d_rty !== 1'b1 || d_ack !== 1'b0 || i_ack !== 1'b0) begin
        errors++; $display("FAIL retry_hold_%0d got cyc=%b adr=%h drty=%b dack=%b iack=%b exp 1/3a5/1/0/0", c, l2_cyc, l2_adr, d_rty, d_ack, i_ack);
      end
      tick();
    end
    l2_rty = 1'b0;
    l2_ack = 1'b1;
    settle();
    checks++; if (d_ack !== 1'b1 || d_rty !== 1'b0 || i_ack !== 1'b0) begin errors++; $display("FAIL retry_ack got dack=%b drty=%b iack=%b exp 1/0/0", d_ack, d_rty, i_ack); end
    tick();
    l2_ack = 1'b0;
    d_cyc = 1'b0; d_stb = 1'b0;
    settle();
    checks++; if (d_ack !== 1'b0 || l2_cyc !== 1'b0) begin errors++; $display("FAIL retry_once got dack=%b cyc=%b exp 0/0", d_ack, l2_cyc); end
    tick();
    clear_inputs();
  endtask

  task automatic test_abort();
    do_reset();
    req_i_on(12'h0AB);
    tick();
    req_d_on(12'h0CD, 1'b0);
    settle();
    checks++; if (l2_cyc !== 1'b1 || l2_adr !== 12'h0AB || d_rty !== 1'b1) begin errors++; $display("FAIL abort_grant got cyc=%b adr=%h drty=%b exp 1/0ab/1", l2_cyc, l2_adr, d_rty); end
    tick();
    i_stb = 1'b0;
    settle();
    checks++; if (l2_stb !== 1'b0 || i_ack !== 1'b0) begin errors++; $display("FAIL abort_stb got stb=%b iack=%b exp 0/0", l2_stb, i_ack); end
    tick();
    i_cyc = 1'b0;
    settle();
    checks++; if (l2_cyc !== 1'b0) begin errors++; $display("FAIL abort_idle got cyc=%b exp 0", l2_cyc); end
    tick(); settle();
    checks++; if (l2_cyc !== 1'b1 || l2_adr !== 12'h0CD) begin errors++; $display("FAIL abort_d_grant got cyc=%b adr=%h exp 1/0cd", l2_cyc, l2_adr); end
    tick();
    clear_inputs();
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    req_d_on(12'h7E1, 1'b0);
    tick(); settle();
    checks++; if (l2_cyc !== 1'b1 || l2_adr !== 12'h7E1) begin errors++; $display("FAIL rstmid_grant got cyc=%b adr=%h exp 1/7e1", l2_cyc, l2_adr); end
    tick();
    rst = 1'b1;
    l2_ack = 1'b1;
    settle();
    checks++; if (l2_cyc !== 1'b0 || d_ack !== 1'b0) begin errors++; $display("FAIL rstmid_rst_cycle got cyc=%b dack=%b exp 0/0", l2_cyc, d_ack); end
    tick();
    rst = 1'b0;
    l2_ack = 1'b0;
    settle();
    checks++; if (l2_cyc !== 1'b0 || d_ack !== 1'b0 || d_rty !== 1'b1) begin errors++; $display("FAIL rstmid_idle got cyc=%b dack=%b drty=%b exp 0/0/1", l2_cyc, d_ack, d_rty); end
    tick(); settle();
    checks++; if (l2_cyc !== 1'b1 || l2_adr !== 12'h7E1) begin errors++; $display("FAIL rstmid_regrant got cyc=%b adr=%h exp 1/7e1", l2_cyc, l2_adr); end
    tick();
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    test_reset();
    test_single_read();
    test_both_from_reset();
    test_back_to_back();
    test_retry_hold();
    test_abort();
    test_reset_mid_grant();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/l2_arbiter.md
Name: l2_arbiter

Overview:
- Two-master to one-slave wishbone arbiter that shares the unified L2 cache between the L1 instruction cache and the L1 data cache.
- Sits between the two L1 cache wishbone master ports and the L2 cache wishbone slave port.
- Grants one 128-bit line transaction at a time, with round-robin fairness.
- Presents the codebase's wishbone retry/ack semantics to each L1.

Parameters:
ADDR_W, 12, line address width (ADR)
DATA_W, 128, line data width
SEL_W, 16, byte-select width

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
i_cyc, i_stb, i_we  input  1 each  I-cache master request controls
i_adr  input  ADDR_W  I-cache line address
i_sel  input  SEL_W  I-cache byte selects
i_dat_m  input  DATA_W  I-cache write data
i_ack, i_rty  output  1 each  I-cache ack / retry
d_cyc, d_stb, d_we  input  1 each  D-cache master request controls
d_adr  input  ADDR_W  D-cache line address
d_sel  input  SEL_W  D-cache byte selects
d_dat_m  input  DATA_W  D-cache write data
d_ack, d_rty  output  1 each  D-cache ack / retry
dat_s  output  DATA_W  L2 read data, broadcast to both masters
l2_cyc, l2_stb, l2_we  output  1 each  forwarded request to L2
l2_adr  output  ADDR_W  forwarded address
l2_sel  output  SEL_W  forwarded selects
l2_dat_m  output  DATA_W  forwarded write data
l2_dat_s  input  DATA_W  L2 read data
l2_ack, l2_rty  input  1 each  L2 ack / retry

Behaviour:
- Request definitions: req_i = i_cyc & i_stb; req_d = d_cyc & d_stb.
- State machine: IDLE, GRANT_I, GRANT_D (registered). last_grant is a 1-bit register; 0 = I, 1 = D.
- Reset: state = IDLE, last_grant = D, so I wins the first tie. In the reset cycle and the cycle after it, all l2_* outputs, i_ack and d_ack are 0. Reset mid-transaction abandons the grant with no ack; the L1 re-presents its request.
- IDLE transitions:
  - req_i only -> GRANT_I.
  - req_d only -> GRANT_D.
  - both -> the master not equal to last_grant.
  - none -> stay in IDLE.
  - l2_cyc/l2_stb are 0 in IDLE. Every request costs one arbitration cycle.
- GRANT_x forwarding:
  - l2_cyc = x_cyc, l2_stb = x_stb.
  - l2_we, l2_adr, l2_sel and l2_dat_m are taken combinationally from master x.
  - x_ack = l2_ack; the other master's ack = 0.
  - When not granted, l2_we/adr/sel/dat_m = 0.
- Leaving GRANT_x: exit to IDLE on l2_ack, or when req_x drops (abort). On exit, last_grant <= x. l2_rty is ignored for sequencing; the grant is held through it.
- Retry: x_rty = req_x & ~x_ack, every cycle in every state, which covers ungranted, arbitrating and waiting. Hence x_rty and x_ack are never both 1.
- dat_s = l2_dat_s, unconditionally.
- Back-to-back: the cycle after an ack is always IDLE. With both masters continuously requesting, grants strictly alternate: I, D, I, D...
- Simultaneous events: ack and a new request from the other master in the same cycle -> IDLE next cycle, then grant the other master. A request arriving during a grant waits, with rty=1.
- No combinational path from l2_ack to any l2_* output.
- Scope: no buffering, no timeout.

Test Plan:
- Reset, then req_i only, read at adr 0x012: cycle 1 IDLE; cycle 2 l2_adr=0x012, l2_we=0, i_rty=1. L2 acks in cycle 4 -> i_ack=1, i_rty=0 in cycle 4; l2_stb=0 in cycle 5.
- Both request from reset (I read 0x100, D write 0x200 with dat 0xDEAD..): I granted first and d_rty=1 throughout. After I's ack: one IDLE cycle, then l2_adr=0x200, l2_we=1, l2_dat_m matches, l2_sel=0xFFFF.
- Both held requesting for 4 transactions -> grant order I, D, I, D; i_ack and d_ack never both 1 in the same cycle.
- D granted and L2 returns rty for 10 cycles -> grant held, d_rty=1, i_ack=0. Then ack -> d_ack=1 once.
- I granted, i_stb drops before ack -> l2_stb=0 that cycle, IDLE next, and a pending D request is granted.
- rst asserted while GRANT_D is waiting -> next cycle l2_cyc=0, no d_ack, state IDLE; the D request re-granted after rst drops.
